// File: rtl/sbm_pkg.sv
// Shared definitions for the shift-add multiplier / restoring divider pair:
// controller state encoding and a counter-width helper.
package sbm_pkg;

  typedef enum logic [0:0] {
    S_idle = 1'b0,
    S_div  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sequential_binary_divider_if.sv
// Start/Ready request bus of the sequential divider: operands in, results and flags out.
interface sequential_binary_divider_if #(
  parameter int dp_width = 4
);
  logic                    Start;
  logic [2*dp_width-1:0]   Dividend;
  logic [dp_width-1:0]     Divisor;
  logic [dp_width-1:0]     Quotient;
  logic [dp_width-1:0]     Remainder;
  logic                    Ready;
  logic                    Div_by_zero;
  logic                    Overflow;

  modport master (
    output Start, Dividend, Divisor,
    input  Quotient, Remainder, Ready, Div_by_zero, Overflow
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Quotient, Remainder, Ready, Div_by_zero, Overflow
  );
endinterface

// File: rtl/divider_datapath.sv
// Restoring-division datapath: E/A/Q/B registers, step counter P, the one-bit
// left shift and the (n+1)-bit trial subtract that decides each quotient bit.
module divider_datapath
  import sbm_pkg::*;
#(
  parameter int dp_width = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  clear,
  input  logic [2*dp_width-1:0] dividend,
  input  logic [dp_width-1:0]   divisor,
  output logic [dp_width-1:0]   quotient,
  output logic [dp_width-1:0]   remainder,
  output logic                  last
);
  localparam int PW = clog2(dp_width + 1);

  logic                e;
  logic [dp_width-1:0] a, q, b;
  logic [PW-1:0]       p;

  logic                e_sh;
  logic [dp_width-1:0] a_sh, q_sh, diff;
  logic                ge;

  // E catches the bit shifted out of A, so {E,A} may exceed B's range before the subtract.
  assign {e_sh, a_sh, q_sh} = {e, a, q} << 1;
  assign ge   = {e_sh, a_sh} >= {1'b0, b};
  assign diff = a_sh - b;

  assign quotient  = q;
  assign remainder = a;
  assign last      = (p == PW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      e <= 1'b0;
      a <= '0;
      q <= '0;
      b <= '0;
      p <= '0;
    end else if (load) begin
      e <= 1'b0;
      a <= dividend[2*dp_width-1:dp_width];
      q <= dividend[dp_width-1:0];
      b <= divisor;
      p <= PW'(dp_width);
    end else if (clear) begin
      e <= 1'b0;
      a <= '0;
      q <= '0;
      p <= '0;
    end else if (step) begin
      e <= 1'b0;
      a <= ge ? diff : a_sh;
      q <= {q_sh[dp_width-1:1], ge};
      p <= p - PW'(1);
    end
  end

endmodule

// File: rtl/sequential_binary_divider.sv
// Sequential restoring divider top: Start/Ready controller, error flags, and
// the datapath producing one quotient bit per clock.
module sequential_binary_divider
  import sbm_pkg::*;
#(
  parameter int dp_width = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  sequential_binary_divider_if.slave  bus
);
  state_t state;
  logic   ready, div_by_zero, overflow;
  logic   accept, bad_zero, bad_range, load, clear, step, last;

  assign accept    = (state == S_idle) && bus.Start;
  assign bad_zero  = (bus.Divisor == '0);
  assign bad_range = !bad_zero && (bus.Dividend[2*dp_width-1:dp_width] >= bus.Divisor);
  assign load      = accept && !bad_zero && !bad_range;
  assign clear     = accept && (bad_zero || bad_range);
  assign step      = (state == S_div);

  divider_datapath #(.dp_width(dp_width)) u_datapath (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .clear     (clear),
    .dividend  (bus.Dividend),
    .divisor   (bus.Divisor),
    .quotient  (bus.Quotient),
    .remainder (bus.Remainder),
    .last      (last)
  );

  assign bus.Ready       = ready;
  assign bus.Div_by_zero = div_by_zero;
  assign bus.Overflow    = overflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_idle;
      ready       <= 1'b1;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_idle: begin
          if (bus.Start) begin
            div_by_zero <= bad_zero;
            overflow    <= bad_range;
            if (load) begin
              state <= S_div;
              ready <= 1'b0;
            end
          end
        end
        S_div: begin
          if (last) begin
            state <= S_idle;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= S_idle;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_binary_divider.sv
// Scoreboard bench for the sequential divider: directed vectors push expected
// results; an independent monitor pops and compares whenever a result appears.
module tb_sequential_binary_divider;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
    int         busy;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  sequential_binary_divider_if #(.dp_width(4)) bus ();

  sequential_binary_divider #(.dp_width(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] q, input logic [3:0] r,
                              input logic dbz, input logic ovf, input int busy);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.busy = busy;
    return e;
  endfunction

  // Monitor: a result is presented on a Ready rise, or right after an accepted
  // Start that left Ready high (error request).
  logic st_edge, rdy_edge, rst_edge;
  int   busy_cnt = 0;
  exp_t got;

  initial begin
    forever begin
      @(posedge clock);
      st_edge  = bus.Start;
      rdy_edge = bus.Ready;
      rst_edge = reset;
      #1;
      if (bus.Ready === 1'b0) begin
        busy_cnt++;
      end else if (rdy_edge !== 1'b1 || (st_edge === 1'b1 && rst_edge === 1'b0)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got Q=%0h R=%0h with empty scoreboard",
                   bus.Quotient, bus.Remainder);
        end else begin
          got = sb.pop_front();
          check("quotient",    int'(bus.Quotient),    int'(got.q));
          check("remainder",   int'(bus.Remainder),   int'(got.r));
          check("div_by_zero", int'(bus.Div_by_zero), int'(got.dbz));
          check("overflow",    int'(bus.Overflow),    int'(got.ovf));
          if (rdy_edge !== 1'b1 && got.busy >= 0)
            check("busy_cycles", busy_cnt, got.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] dvd, input logic [3:0] dvs,
                       input bit push, input exp_t e);
    @(negedge clock);
    bus.Start    = 1'b1;
    bus.Dividend = dvd;
    bus.Divisor  = dvs;
    if (push) sb.push_back(e);
    @(negedge clock);
    bus.Start    = 1'b0;
    bus.Dividend = 8'($urandom);
    bus.Divisor  = 4'($urandom);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 20; i++) begin
      if (bus.Ready === 1'b1) break;
      @(negedge clock);
    end
    if (bus.Ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: Ready=%b after 20 cycles, expected 1", bus.Ready);
    end
  endtask

  initial begin
    bus.Start    = 1'b0;
    bus.Dividend = 8'h00;
    bus.Divisor  = 4'h0;
    sb.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, -1));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    issue(8'h48, 4'h9, 1'b1, mk(4'h8, 4'h0, 1'b0, 1'b0, 4)); wait_idle();
    issue(8'h8F, 4'h9, 1'b1, mk(4'hF, 4'h8, 1'b0, 1'b0, 4)); wait_idle();
    issue(8'h12, 4'h0, 1'b1, mk(4'h0, 4'h0, 1'b1, 1'b0, 0)); wait_idle();
    issue(8'h2A, 4'h7, 1'b1, mk(4'h6, 4'h0, 1'b0, 1'b0, 4)); wait_idle();
    issue(8'h90, 4'h9, 1'b1, mk(4'h0, 4'h0, 1'b0, 1'b1, 0)); wait_idle();
    issue(8'hFF, 4'hF, 1'b1, mk(4'h0, 4'h0, 1'b0, 1'b1, 0)); wait_idle();
    issue(8'hE7, 4'hF, 1'b1, mk(4'hF, 4'h6, 1'b0, 1'b0, 4)); wait_idle();
    issue(8'h3F, 4'h4, 1'b1, mk(4'hF, 4'h3, 1'b0, 1'b0, 4)); wait_idle();
    issue(8'h77, 4'h8, 1'b1, mk(4'hE, 4'h7, 1'b0, 1'b0, 4)); wait_idle();
    issue(8'h00, 4'h1, 1'b1, mk(4'h0, 4'h0, 1'b0, 1'b0, 4)); wait_idle();

    // Second Start during a busy division must be ignored.
    issue(8'h48, 4'h9, 1'b1, mk(4'h8, 4'h0, 1'b0, 1'b0, 4));
    @(negedge clock);
    bus.Start    = 1'b1;
    bus.Dividend = 8'h8F;
    bus.Divisor  = 4'h9;
    @(negedge clock);
    bus.Start    = 1'b0;
    wait_idle();

    // Reset in the middle of a division aborts it and clears everything.
    sb.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, -1));
    issue(8'h48, 4'h9, 1'b0, mk(4'h0, 4'h0, 1'b0, 1'b0, -1));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    issue(8'h21, 4'h5, 1'b1, mk(4'h6, 4'h3, 1'b0, 1'b0, 4)); wait_idle();

    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
